// File: rtl/motor_controller_sysid_pkg.sv
// Shared types and default constants for the sysid checker.
// Holds the FSM state enum and the expected ID/timestamp defaults.
package motor_controller_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_state_e;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'h2014_0830;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h5400_E662;
  localparam int          WAIT_CNT_W                 = 4;

endpackage

// File: rtl/motor_controller_sysid_ticker.sv
// Free-running recheck timer; pulses tick on the first cycle after reset
// and then once every PERIOD cycles. Used only with SYSID_CHECK_PERIODIC_EN.
module motor_controller_sysid_ticker #(
  parameter int unsigned PERIOD = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  logic [31:0] count;
  logic        first;
  logic        wrap;

  assign wrap = (count == 32'(PERIOD - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      count <= wrap ? '0 : count + 32'd1;
    end
  end

  assign tick = first | wrap;

endmodule

// File: rtl/motor_controller_sysid_checker.sv
// Reads the sysid slave (ID at address 0, timestamp at address 1) and
// compares both words. Optional periodic recheck: SYSID_CHECK_PERIODIC_EN.
module motor_controller_sysid_checker
  import motor_controller_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          READ_WAIT          = 1,
  parameter int unsigned RECHECK_PERIOD     = 1_000_000
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         sysid_address,
  input  logic [31:0]  sysid_readdata,
  output logic [31:0]  id_value,
  output logic [31:0]  ts_value,
  output logic         busy,
  output logic         done,
  output logic         match,
  output logic         id_err,
  output logic         ts_err,
  output sysid_state_e state_dbg
);

  if (READ_WAIT < 1 || READ_WAIT > 15) begin : g_bad_read_wait
    $error("READ_WAIT must be in 1..15");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(READ_WAIT - 1);

  // start is a one-cycle request honoured only in IDLE/DONE (dropped while
  // busy); done stays high from completion until the next accepted start.
  logic start_int;

`ifdef SYSID_CHECK_PERIODIC_EN
  logic tick;

  motor_controller_sysid_ticker #(
    .PERIOD (RECHECK_PERIOD)
  ) u_ticker (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign start_int = start | tick;
`else
  assign start_int = start;
`endif

  sysid_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           id_d, ts_d;
  logic                  busy_d, done_d, match_d, id_err_d, ts_err_d;
  logic                  id_bad, ts_bad;

  assign id_bad = (id_value != EXPECTED_ID);
  assign ts_bad = (sysid_readdata != EXPECTED_TIMESTAMP);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_value;
    ts_d     = ts_value;
    busy_d   = busy;
    done_d   = done;
    match_d  = match;
    id_err_d = id_err;
    ts_err_d = ts_err;
    case (state_q)
      IDLE, DONE: begin
        if (start_int) begin
          state_d  = RD_ID;
          cnt_d    = WAIT_INIT;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          match_d  = 1'b0;
          id_err_d = 1'b0;
          ts_err_d = 1'b0;
        end
      end
      RD_ID: begin
        if (cnt_q == '0) begin
          id_d    = sysid_readdata;
          cnt_d   = WAIT_INIT;
          state_d = RD_TS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_TS: begin
        if (cnt_q == '0) begin
          // Timestamp is judged on the word being captured this cycle.
          ts_d     = sysid_readdata;
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          id_err_d = id_bad;
          ts_err_d = ts_bad;
          match_d  = !(id_bad | ts_bad);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      id_value <= '0;
      ts_value <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      id_err   <= 1'b0;
      ts_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_value <= id_d;
      ts_value <= ts_d;
      busy     <= busy_d;
      done     <= done_d;
      match    <= match_d;
      id_err   <= id_err_d;
      ts_err   <= ts_err_d;
    end
  end

  assign sysid_address = (state_q == RD_TS);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_motor_controller_sysid_checker.sv
// Directed bench: instance A (READ_WAIT=1, ideal slave) and instance B
// (READ_WAIT=4, slave whose data is valid only from the 3rd address cycle).
module tb_motor_controller_sysid_checker;
  import motor_controller_sysid_pkg::*;

  localparam logic [31:0] GOOD_ID = 32'h2014_0830;
  localparam logic [31:0] GOOD_TS = 32'h5400_E662;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;

  logic         addr_a, busy_a, done_a, match_a, id_err_a, ts_err_a;
  logic [31:0]  rdata_a, id_val_a, ts_val_a;
  sysid_state_e state_a;
  logic         addr_b, busy_b, done_b, match_b, id_err_b, ts_err_b;
  logic [31:0]  rdata_b, id_val_b, ts_val_b;
  sysid_state_e state_b;

  logic [31:0] slave_id_a = GOOD_ID;
  logic [31:0] slave_ts_a = GOOD_TS;
  int          age_b = 0;
  logic        prev_addr_b = 1'b0;
  int          addr0_cycles_b = 0, addr1_cycles_b = 0;

  int tests = 0;
  int fails = 0;

  // clock / reset
  always #5 clock = ~clock;

  // slave models
  assign rdata_a = addr_a ? slave_ts_a : slave_id_a;
  assign rdata_b = (age_b >= 3) ? (addr_b ? GOOD_TS : GOOD_ID) : 32'hDEAD_BEEF;

  always @(negedge clock) begin
    if (!busy_b) age_b = 0;
    else if (addr_b != prev_addr_b) age_b = 1;
    else age_b = age_b + 1;
    prev_addr_b = addr_b;
    if (busy_b && !addr_b) addr0_cycles_b = addr0_cycles_b + 1;
    if (busy_b && addr_b) addr1_cycles_b = addr1_cycles_b + 1;
  end

  motor_controller_sysid_checker #(.READ_WAIT(1)) u_dut_a (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start_a),
    .sysid_address  (addr_a),
    .sysid_readdata (rdata_a),
    .id_value       (id_val_a),
    .ts_value       (ts_val_a),
    .busy           (busy_a),
    .done           (done_a),
    .match          (match_a),
    .id_err         (id_err_a),
    .ts_err         (ts_err_a),
    .state_dbg      (state_a)
  );

  motor_controller_sysid_checker #(.READ_WAIT(4)) u_dut_b (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start_b),
    .sysid_address  (addr_b),
    .sysid_readdata (rdata_b),
    .id_value       (id_val_b),
    .ts_value       (ts_val_b),
    .busy           (busy_b),
    .done           (done_b),
    .match          (match_b),
    .id_err         (id_err_b),
    .ts_err         (ts_err_b),
    .state_dbg      (state_b)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: request a check on A (sel=0) or B (sel=1); returns cycles to done
  task automatic run_check(input bit sel, input bit hold, output int lat);
    lat = -1;
    @(negedge clock);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      if (sel ? done_b : done_a) begin
        lat = n;
        break;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int lat;
    int a0, a1;

    repeat (3) @(negedge clock);
    check("reset_done",  {31'd0, done_a},  32'd0);
    check("reset_busy",  {31'd0, busy_a},  32'd0);
    check("reset_addr",  {31'd0, addr_a},  32'd0);
    check("reset_state", {30'd0, state_a}, {30'd0, IDLE});
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_no_done", {31'd0, done_a}, 32'd0);

    // A: nominal check, latency 3
    run_check(1'b0, 1'b0, lat);
    check("a_latency",  32'(lat),           32'd3);
    check("a_match",    {31'd0, match_a},   32'd1);
    check("a_id_err",   {31'd0, id_err_a},  32'd0);
    check("a_ts_err",   {31'd0, ts_err_a},  32'd0);
    check("a_id_value", id_val_a,           GOOD_ID);
    check("a_ts_value", ts_val_a,           GOOD_TS);
    check("a_busy_end", {31'd0, busy_a},    32'd0);
    repeat (4) @(negedge clock);
    check("a_done_sticky", {31'd0, done_a}, 32'd1);
    check("a_addr_done",   {31'd0, addr_a}, 32'd0);

    // A: ID off by one bit
    slave_id_a = 32'h2014_0831;
    run_check(1'b0, 1'b0, lat);
    check("a_bad_id_latency", 32'(lat),          32'd3);
    check("a_bad_id_match",   {31'd0, match_a},  32'd0);
    check("a_bad_id_id_err",  {31'd0, id_err_a}, 32'd1);
    check("a_bad_id_ts_err",  {31'd0, ts_err_a}, 32'd0);
    check("a_bad_id_value",   id_val_a,          32'h2014_0831);
    slave_id_a = GOOD_ID;

    // A: timestamp mismatch in the top bit only
    slave_ts_a = 32'hD400_E662;
    run_check(1'b0, 1'b0, lat);
    check("a_bad_ts_match",  {31'd0, match_a},  32'd0);
    check("a_bad_ts_id_err", {31'd0, id_err_a}, 32'd0);
    check("a_bad_ts_ts_err", {31'd0, ts_err_a}, 32'd1);
    check("a_bad_ts_value",  ts_val_a,          32'hD400_E662);
    slave_ts_a = GOOD_TS;

    // B: READ_WAIT=4, latency 9, address held 4 cycles each
    a0 = addr0_cycles_b;
    a1 = addr1_cycles_b;
    run_check(1'b1, 1'b0, lat);
    check("b_latency",   32'(lat),                  32'd9);
    check("b_match",     {31'd0, match_b},          32'd1);
    check("b_id_value",  id_val_b,                  GOOD_ID);
    check("b_ts_value",  ts_val_b,                  GOOD_TS);
    check("b_addr0_len", 32'(addr0_cycles_b - a0),  32'd4);
    check("b_addr1_len", 32'(addr1_cycles_b - a1),  32'd4);

    // B: start held every cycle during the check
    run_check(1'b1, 1'b1, lat);
    check("b_hold_latency", 32'(lat),         32'd9);
    check("b_hold_match",   {31'd0, match_b}, 32'd1);
    @(negedge clock);
    check("b_hold_no_restart", {31'd0, busy_b}, 32'd0);

    // A: new start clears done; reset during RD_TS abandons the check
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("a_restart_clears_done", {31'd0, done_a}, 32'd0);
    check("a_restart_busy",        {31'd0, busy_a}, 32'd1);
    @(negedge clock);
    check("a_in_rd_ts", {30'd0, state_a}, {30'd0, RD_TS});
    check("a_addr_ts",  {31'd0, addr_a},  32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy",     {31'd0, busy_a},  32'd0);
    check("rst_done",     {31'd0, done_a},  32'd0);
    check("rst_addr",     {31'd0, addr_a},  32'd0);
    check("rst_id_value", id_val_a,         32'd0);
    check("rst_ts_value", ts_val_a,         32'd0);
    check("rst_match",    {31'd0, match_a}, 32'd0);
    check("rst_state",    {30'd0, state_a}, {30'd0, IDLE});
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("post_rst_no_done", {31'd0, done_a}, 32'd0);
    check("post_rst_idle",    {30'd0, state_a}, {30'd0, IDLE});

    run_check(1'b0, 1'b0, lat);
    check("post_rst_latency", 32'(lat),         32'd3);
    check("post_rst_match",   {31'd0, match_a}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motor_controller_sysid_checker.md
MOTOR_CONTROLLER_SYSID_CHECKER -- requirements
Module: motor_controller_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h2014_0830: system ID value the sysid slave must return at address 0.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'h5400_E662: build timestamp the slave must return at address 1.
REQ-003 SHALL have parameter READ_WAIT, default 1, range 1..15: cycles address is held before readdata is sampled.
REQ-004 SHALL have parameter RECHECK_PERIOD, default 1_000_000: cycles between automatic rechecks (used only with REQ-030).
REQ-005 clock  input  1  single system clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle pulse that requests a check.
REQ-008 sysid_address  output  1  address to sysid control slave (0 = ID, 1 = timestamp).
REQ-009 sysid_readdata  input  32  read data from sysid control slave.
REQ-010 id_value  output  32  last captured ID word.
REQ-011 ts_value  output  32  last captured timestamp word.
REQ-012 busy  output  1  high while a check is in progress.
REQ-013 done  output  1  sticky; high once a check completes, until the next check starts.
REQ-014 match  output  1  valid when done=1; 1 iff both words equal their expected values.
REQ-015 id_err  output  1  valid when done=1; ID word mismatched.
REQ-016 ts_err  output  1  valid when done=1; timestamp word mismatched.

Function
REQ-017 FSM states SHALL be IDLE, RD_ID, RD_TS, DONE.
REQ-018 IDLE/DONE + start=1 SHALL enter RD_ID next cycle, clear done/match/id_err/ts_err, set busy=1, load wait counter with READ_WAIT-1.
REQ-019 RD_ID SHALL drive sysid_address=0; when counter is 0, capture sysid_readdata into id_value, reload counter, enter RD_TS.
REQ-020 RD_TS SHALL drive sysid_address=1; when counter is 0, capture into ts_value, enter DONE.
REQ-021 Entering DONE SHALL register done=1, busy=0, id_err=(id_value!=EXPECTED_ID), ts_err=(captured ts!=EXPECTED_TIMESTAMP), match=!(id_err|ts_err), all in one cycle.
REQ-022 Latency from start to done=1 SHALL be exactly 2*READ_WAIT+1 cycles.
REQ-023 start while busy=1 SHALL be ignored; no restart, no queueing.
REQ-024 sysid_address SHALL be 0 in IDLE and DONE.
REQ-025 Counter SHALL be 4 bits; READ_WAIT outside 1..15 SHALL fail elaboration.
REQ-026 Comparisons SHALL be full 32-bit equality; no masking.

Reset
REQ-027 reset_n=0 SHALL force, asynchronously: state IDLE, sysid_address 0, id_value 0, ts_value 0, busy 0, done 0, match 0, id_err 0, ts_err 0, counters 0.
REQ-028 Reset mid-check SHALL abandon the check; no partial result is reported.
REQ-029 After release, the block SHALL wait in IDLE for start (or REQ-030 trigger).

Configuration
REQ-030 With SYSID_CHECK_PERIODIC_EN defined: 32-bit period counter SHALL run from reset; on reaching RECHECK_PERIOD-1 it SHALL wrap to 0 and issue an internal start, and the first check SHALL auto-start one cycle after reset release; internal start while busy is dropped per REQ-023; external start still works.
REQ-031 Without SYSID_CHECK_PERIODIC_EN: no period counter SHALL exist; checks occur only on external start.

Structure
REQ-032 Shared package motor_controller_sysid_pkg SHALL hold the FSM state enum and default EXPECTED_ID/EXPECTED_TIMESTAMP constants.
REQ-033 Wait counter SHALL be inline; period timer SHALL be sub-module motor_controller_sysid_ticker, instantiated only under SYSID_CHECK_PERIODIC_EN.

Verification
REQ-034 Slave model returns 0x20140830/0x5400E662, READ_WAIT=1, start pulse -> done=1 after 3 cycles, match=1, id_err=0, ts_err=0, id_value=0x20140830.
REQ-035 Slave returns 0x20140831 at address 0 -> done=1, match=0, id_err=1, ts_err=0.
REQ-036 READ_WAIT=4, data valid only from 3rd cycle of each address -> done after 9 cycles, correct values captured, address held 4 cycles each.
REQ-037 start repeated every cycle during check -> single check, done after 2*READ_WAIT+1 cycles from first start.
REQ-038 reset_n low during RD_TS -> all outputs 0 immediately; no done after release until new start.
REQ-039 SYSID_CHECK_PERIODIC_EN, RECHECK_PERIOD=20 -> check auto-starts after reset, then every 20 cycles; done drops for the duration of each recheck.
